// File: rtl/samp_cmp_pkg.sv
// Shared types and defaults for the sample comparator.
// Optional per-bit mask path is enabled by defining SAMP_CMP_MASK_EN.
package samp_cmp_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/samp_cmp_if.sv
// Tester-facing bundle of the sample comparator.
// EXP_MASK exists only when SAMP_CMP_MASK_EN is defined.
interface samp_cmp_if
  import samp_cmp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  localparam int LW = lvl_w(DEPTH);

  logic             CLR;
  logic             EXP_PUSH;
  logic [DW-1:0]    EXP_DATA;
`ifdef SAMP_CMP_MASK_EN
  logic [DW-1:0]    EXP_MASK;
`endif
  logic             ARM;
  logic [DW-1:0]    SAMP_DATA;
  logic             SAMP_VALID;
  logic             EXP_FULL;
  logic [LW-1:0]    EXP_LEVEL;
  logic             BUSY;
  logic             CMP_DONE;
  logic             CMP_PASS;
  logic [CNT_W-1:0] FAIL_CNT;
  logic [CNT_W-1:0] SAMP_IDX;
  logic [CNT_W-1:0] FIRST_FAIL_IDX;
  logic [DW-1:0]    FIRST_FAIL_DATA;
  logic [DW-1:0]    FIRST_FAIL_EXP;
  logic             OVERFLOW;
  logic             STRAY;

  modport master (
    output CLR, EXP_PUSH, EXP_DATA,
`ifdef SAMP_CMP_MASK_EN
    EXP_MASK,
`endif
    ARM, SAMP_DATA, SAMP_VALID,
    input  EXP_FULL, EXP_LEVEL, BUSY,
    CMP_DONE, CMP_PASS, FAIL_CNT,
    SAMP_IDX, FIRST_FAIL_IDX,
    FIRST_FAIL_DATA, FIRST_FAIL_EXP,
    OVERFLOW, STRAY
  );

  modport slave (
    input  CLR, EXP_PUSH, EXP_DATA,
`ifdef SAMP_CMP_MASK_EN
    EXP_MASK,
`endif
    ARM, SAMP_DATA, SAMP_VALID,
    output EXP_FULL, EXP_LEVEL, BUSY,
    CMP_DONE, CMP_PASS, FAIL_CNT,
    SAMP_IDX, FIRST_FAIL_IDX,
    FIRST_FAIL_DATA, FIRST_FAIL_EXP,
    OVERFLOW, STRAY
  );

endinterface

// File: rtl/samp_cmp_fifo.sv
// Show-ahead synchronous FIFO for expected entries.
// Pushes while full are dropped; pops while empty are ignored.
module samp_cmp_fifo
  import samp_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/samp_compare.sv
// Compares strobed samples against a preloaded expected queue.
// Define SAMP_CMP_MASK_EN to store a per-entry compare mask.
module samp_compare
  import samp_cmp_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int EXP_DEPTH = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic     CLK,
  input  logic     RST_N,
  samp_cmp_if.slave bus
);

  localparam int LW = lvl_w(EXP_DEPTH);
`ifdef SAMP_CMP_MASK_EN
  localparam int FW = 2 * DW;
`else
  localparam int FW = DW;
`endif

  logic [FW-1:0]    push_word, head;
  logic [DW-1:0]    exp_data, exp_mask;
  logic             full, empty, pop;
  logic [LW-1:0]    level;
  logic             push_ok, mism;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [DW-1:0]    ffd_q, ffd_d;
  logic [DW-1:0]    ffe_q, ffe_d;
  logic             ovf_q, ovf_d;
  logic             stray_q, stray_d;
  logic             done_q, done_d;

`ifdef SAMP_CMP_MASK_EN
  assign push_word = {bus.EXP_MASK, bus.EXP_DATA};
  assign exp_data  = head[DW-1:0];
  assign exp_mask  = head[FW-1:DW];
`else
  assign push_word = bus.EXP_DATA;
  assign exp_data  = head;
  assign exp_mask  = '1;
`endif

  assign pop     = (state_q == RUN) && bus.SAMP_VALID;
  assign push_ok = bus.EXP_PUSH && !full;
  assign mism    = |((bus.SAMP_DATA ^ exp_data) & exp_mask);

  samp_cmp_fifo #(
    .WIDTH (FW),
    .DEPTH (EXP_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr_i   (bus.CLR),
    .push_i  (bus.EXP_PUSH),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    idx_d   = idx_q;
    ffi_d   = ffi_q;
    ffd_d   = ffd_q;
    ffe_d   = ffe_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (bus.EXP_PUSH & full);
    stray_d = stray_q;
    unique case (state_q)
      RUN: begin
        if (bus.SAMP_VALID) begin
          if (mism) begin
            if (fail_q == '0) begin
              ffi_d = idx_q;
              ffd_d = bus.SAMP_DATA;
              ffe_d = exp_data;
            end
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
          end
          if (idx_q != '1) idx_d = idx_q + CNT_W'(1);
          if (level == LW'(1) && !push_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      IDLE, DONE: begin
        if (bus.ARM) begin
          // a new run starts clean except for the overflow history
          if (state_q == DONE) begin
            fail_d  = '0;
            idx_d   = '0;
            ffi_d   = '0;
            ffd_d   = '0;
            ffe_d   = '0;
            stray_d = 1'b0;
          end
          state_d = empty ? DONE : RUN;
          done_d  = empty;
        end
        if (bus.SAMP_VALID) stray_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bus.CLR) begin
      state_d = IDLE;
      fail_d  = '0;
      idx_d   = '0;
      ffi_d   = '0;
      ffd_d   = '0;
      ffe_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      stray_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      fail_q  <= '0;
      idx_q   <= '0;
      ffi_q   <= '0;
      ffd_q   <= '0;
      ffe_q   <= '0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      idx_q   <= idx_d;
      ffi_q   <= ffi_d;
      ffd_q   <= ffd_d;
      ffe_q   <= ffe_d;
      ovf_q   <= ovf_d;
      stray_q <= stray_d;
      done_q  <= done_d;
    end
  end

  assign bus.EXP_FULL        = full;
  assign bus.EXP_LEVEL       = level;
  assign bus.BUSY            = (state_q == RUN);
  assign bus.CMP_DONE        = done_q;
  assign bus.CMP_PASS        = (state_q == DONE) && (fail_q == '0)
                               && !stray_q;
  assign bus.FAIL_CNT        = fail_q;
  assign bus.SAMP_IDX        = idx_q;
  assign bus.FIRST_FAIL_IDX  = ffi_q;
  assign bus.FIRST_FAIL_DATA = ffd_q;
  assign bus.FIRST_FAIL_EXP  = ffe_q;
  assign bus.OVERFLOW        = ovf_q;
  assign bus.STRAY           = stray_q;

endmodule

// File: tb/tb_samp_compare.sv
// Randomized and directed bench for samp_compare.
// Reference model: expected-byte queues plus a run/done flag.
module tb_samp_compare;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic CLK;
  logic RST_N;

  samp_cmp_if #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  samp_compare #(
    .DW        (DW),
    .EXP_DEPTH (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  logic [DW-1:0] q_d[$];
  logic [DW-1:0] q_m[$];
  int            mst;
  int            m_fail, m_idx, m_ffi;
  logic [DW-1:0] m_ffd, m_ffe;
  bit            m_ovf, m_stray, m_done;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    q_d.delete();
    q_m.delete();
    mst = M_IDLE;
    m_fail = 0; m_idx = 0; m_ffi = 0;
    m_ffd = '0; m_ffe = '0;
    m_ovf = 0; m_stray = 0; m_done = 0;
  endtask

  task automatic model_tick();
    bit push_ok, was_empty;
    logic [DW-1:0] e, m, pm;
    if (!RST_N || bus.CLR) begin
      mreset();
      return;
    end
    m_done = 0;
    push_ok = bus.EXP_PUSH && (q_d.size() < DEPTH);
    if (bus.EXP_PUSH && !push_ok) m_ovf = 1;
    was_empty = (q_d.size() == 0);
    if (mst == M_RUN) begin
      if (bus.SAMP_VALID) begin
        e = q_d.pop_front();
        m = q_m.pop_front();
        if (((bus.SAMP_DATA ^ e) & m) != 0) begin
          if (m_fail == 0) begin
            m_ffi = m_idx;
            m_ffd = bus.SAMP_DATA;
            m_ffe = e;
          end
          if (m_fail < MAXC) m_fail++;
        end
        if (m_idx < MAXC) m_idx++;
        if (q_d.size() == 0 && !push_ok) begin
          mst = M_DONE;
          m_done = 1;
        end
      end
    end else begin
      if (bus.ARM) begin
        if (mst == M_DONE) begin
          m_fail = 0; m_idx = 0; m_ffi = 0;
          m_ffd = '0; m_ffe = '0; m_stray = 0;
        end
        if (was_empty) begin
          mst = M_DONE;
          m_done = 1;
        end else mst = M_RUN;
      end
      if (bus.SAMP_VALID) m_stray = 1;
    end
`ifdef SAMP_CMP_MASK_EN
    pm = bus.EXP_MASK;
`else
    pm = '1;
`endif
    if (push_ok) begin
      q_d.push_back(bus.EXP_DATA);
      q_m.push_back(pm);
    end
  endtask

  task automatic compare_all();
    bit pass;
    pass = (mst == M_DONE) && (m_fail == 0) && !m_stray;
    chk("level", 32'(bus.EXP_LEVEL), q_d.size());
    chk("full", 32'(bus.EXP_FULL), 32'(q_d.size() == DEPTH));
    chk("busy", 32'(bus.BUSY), 32'(mst == M_RUN));
    chk("done", 32'(bus.CMP_DONE), 32'(m_done));
    chk("pass", 32'(bus.CMP_PASS), 32'(pass));
    chk("fail_cnt", 32'(bus.FAIL_CNT), m_fail);
    chk("samp_idx", 32'(bus.SAMP_IDX), m_idx);
    chk("ff_idx", 32'(bus.FIRST_FAIL_IDX), m_ffi);
    chk("ff_data", 32'(bus.FIRST_FAIL_DATA), 32'(m_ffd));
    chk("ff_exp", 32'(bus.FIRST_FAIL_EXP), 32'(m_ffe));
    chk("ovf", 32'(bus.OVERFLOW), 32'(m_ovf));
    chk("stray", 32'(bus.STRAY), 32'(m_stray));
  endtask

  task automatic idle_in();
    bus.CLR = 0;
    bus.EXP_PUSH = 0;
    bus.EXP_DATA = '0;
`ifdef SAMP_CMP_MASK_EN
    bus.EXP_MASK = '1;
`endif
    bus.ARM = 0;
    bus.SAMP_VALID = 0;
    bus.SAMP_DATA = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_tick();
    #1;
    compare_all();
    idle_in();
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    bus.EXP_PUSH = 1;
    bus.EXP_DATA = d;
    step();
  endtask

  task automatic arm_t();
    bus.ARM = 1;
    step();
  endtask

  task automatic samp(input logic [DW-1:0] d);
    bus.SAMP_VALID = 1;
    bus.SAMP_DATA = d;
    step();
  endtask

  task automatic clr_t();
    bus.CLR = 1;
    step();
  endtask

  initial begin
    logic [DW-1:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22;
    bytes[2] = 8'h33; bytes[3] = 8'h44;
    idle_in();
    RST_N = 0;
    mreset();
    #12;
    compare_all();
    chk("rst_level", 32'(bus.EXP_LEVEL), 0);
    RST_N = 1;

    foreach (bytes[i]) push_b(bytes[i]);
    arm_t();
    chk("t1_busy", 32'(bus.BUSY), 1);
    for (int i = 0; i < 3; i++) begin
      samp(bytes[i]);
      chk("t1_nodone", 32'(bus.CMP_DONE), 0);
    end
    samp(bytes[3]);
    chk("t1_done", 32'(bus.CMP_DONE), 1);
    chk("t1_pass", 32'(bus.CMP_PASS), 1);
    chk("t1_idx", 32'(bus.SAMP_IDX), 4);
    step();
    chk("t1_pulse", 32'(bus.CMP_DONE), 0);

    foreach (bytes[i]) push_b(bytes[i]);
    arm_t();
    chk("t2_clr_idx", 32'(bus.SAMP_IDX), 0);
    samp(8'h11);
    samp(8'h22);
    samp(8'h37);
    samp(8'h44);
    chk("t2_fail", 32'(bus.FAIL_CNT), 1);
    chk("t2_ffi", 32'(bus.FIRST_FAIL_IDX), 2);
    chk("t2_ffd", 32'(bus.FIRST_FAIL_DATA), 32'h37);
    chk("t2_ffe", 32'(bus.FIRST_FAIL_EXP), 32'h33);
    chk("t2_pass", 32'(bus.CMP_PASS), 0);

    clr_t();
    for (int i = 0; i < 33; i++) push_b(8'(i));
    chk("t3_full", 32'(bus.EXP_FULL), 1);
    chk("t3_ovf", 32'(bus.OVERFLOW), 1);
    chk("t3_lvl", 32'(bus.EXP_LEVEL), 32);

    clr_t();
    samp(8'h5A);
    chk("t4_stray", 32'(bus.STRAY), 1);
    chk("t4_lvl", 32'(bus.EXP_LEVEL), 0);
    push_b(8'h5A);
    arm_t();
    samp(8'h5A);
    chk("t4_done", 32'(bus.CMP_DONE), 1);
    chk("t4_pass", 32'(bus.CMP_PASS), 0);

    clr_t();
    arm_t();
    chk("t5_done", 32'(bus.CMP_DONE), 1);
    chk("t5_pass", 32'(bus.CMP_PASS), 1);
    chk("t5_idx", 32'(bus.SAMP_IDX), 0);

`ifdef SAMP_CMP_MASK_EN
    clr_t();
    bus.EXP_MASK = 8'hF0;
    push_b(8'hF0);
    arm_t();
    samp(8'hFF);
    chk("mask_fail", 32'(bus.FAIL_CNT), 0);
    chk("mask_pass", 32'(bus.CMP_PASS), 1);
`endif

    clr_t();
    push_b(8'hA1);
    push_b(8'hA2);
    push_b(8'hA3);
    arm_t();
    samp(8'h00);
    RST_N = 0;
    #1;
    mreset();
    compare_all();
    chk("rst_fail", 32'(bus.FAIL_CNT), 0);
    step();
    step();
    chk("rst_nodone", 32'(bus.CMP_DONE), 0);
    RST_N = 1;
    step();

    for (int c = 0; c < 3000; c++) begin
      bus.CLR = ($urandom_range(199) == 0);
      bus.ARM = ($urandom_range(19) == 0);
      bus.EXP_PUSH = ($urandom_range(1) == 0);
      bus.EXP_DATA = 8'($urandom);
`ifdef SAMP_CMP_MASK_EN
      bus.EXP_MASK = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
`endif
      bus.SAMP_VALID = ($urandom_range(2) == 0);
      if (mst == M_RUN && q_d.size() > 0 && $urandom_range(3) != 0)
        bus.SAMP_DATA = q_d[0];
      else
        bus.SAMP_DATA = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
